mesi_snoop_resolver: RTL

//  Consumes the 5-bit bus transaction {core_id, BusRd, BusRdX, BusUpgr} driven onto the shared bus.

---
 rtl/mesi_pkg.sv | 37 +++
 rtl/mesi_next_state_calc.sv | 46 ++++
 rtl/mesi_snoop_resolver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mesi_pkg.sv
// ============================================================================
// Module   : mesi_pkg
// Desc     : MESI encodings, bus_signals bit positions and resolver FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mesi_pkg;

  typedef logic [1:0] mesi_t;

  localparam mesi_t c_MESI_I = 2'b00;
  localparam mesi_t c_MESI_S = 2'b01;
  localparam mesi_t c_MESI_E = 2'b10;
  localparam mesi_t c_MESI_M = 2'b11;

  localparam int c_BIT_UPGR = 0;
  localparam int c_BIT_RDX  = 1;
  localparam int c_BIT_RD   = 2;
  localparam int c_CORE_LSB = 3;

  // One-hot command codes as seen in bus_signals[2:0]
  localparam logic [2:0] c_CMD_RD   = 3'(1 << c_BIT_RD);
  localparam logic [2:0] c_CMD_RDX  = 3'(1 << c_BIT_RDX);
  localparam logic [2:0] c_CMD_UPGR = 3'(1 << c_BIT_UPGR);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SNOOP   = 3'd1,
    ST_RESOLVE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_UPDATE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mesi_next_state_calc.sv
// ============================================================================
// Module   : mesi_next_state_calc
// Desc     : Per-core MESI next state and flush flag for one snooped bus command.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mesi_next_state_calc
  import mesi_pkg::*;
(
  input  logic [2:0] i_cmd,
  input  logic       i_is_requester,
  input  logic [1:0] i_cur_state,
  output logic [1:0] o_nxt_state,
  output logic       o_flush
);

  always_comb begin
    o_nxt_state = i_cur_state;
    o_flush     = 1'b0;
    case (i_cmd)
      c_CMD_RD: begin
        if (i_is_requester) begin
          o_nxt_state = c_MESI_S;
        end else begin
          o_nxt_state = (i_cur_state == c_MESI_I) ? c_MESI_I : c_MESI_S;
          o_flush     = (i_cur_state == c_MESI_M);
        end
      end
      c_CMD_RDX: begin
        o_nxt_state = i_is_requester ? c_MESI_M : c_MESI_I;
        o_flush     = !i_is_requester && (i_cur_state == c_MESI_M);
      end
      // Upgrade invalidates other copies without any write-back
      c_CMD_UPGR: begin
        o_nxt_state = i_is_requester ? c_MESI_M : c_MESI_I;
      end
      default: begin
        o_nxt_state = i_cur_state;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mesi_snoop_resolver.sv
// ============================================================================
// Module   : mesi_snoop_resolver
// Desc     : Snoops all four L1 line states for one bus transaction, resolves a
//            Modified-owner flush and commits every core's new MESI state.
//            Optional stats counters enabled by MESI_BUS_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mesi_snoop_resolver
  import mesi_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 15
`ifdef MESI_BUS_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_valid,
  output logic       bus_ready,
  input  logic [4:0] bus_signals,
  input  logic [7:0] snoop_state,
  output logic       flush_req,
  output logic [1:0] flush_core,
  input  logic       flush_ack,
  output logic [3:0] state_wr_en,
  output logic [7:0] state_wr_data,
  output logic       txn_done,
  output logic       txn_error
`ifdef MESI_BUS_STATS_EN
  , output logic [CNT_W-1:0] cnt_busrd
  , output logic [CNT_W-1:0] cnt_busrdx
  , output logic [CNT_W-1:0] cnt_busupgr
  , output logic [CNT_W-1:0] cnt_flush
`endif
);

  localparam int TMO_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(FLUSH_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_bus_ready;
  logic [2:0]       r_cmd;
  logic [1:0]       r_req;
  logic             r_noop;
  logic             r_err;
  logic [7:0]       r_snoop;
  logic [1:0]       r_flush_core;
  logic [TMO_W-1:0] r_tmo;

  logic             w_accept;
  logic [2:0]       w_cmd_in;
  logic             w_cmd_legal;
  logic [7:0]       w_nxt;
  logic [3:0]       w_flush_vec;
  logic [3:0]       w_changed;
  logic [3:0]       w_is_m;
  logic [3:0]       w_is_se;
  logic [1:0]       w_flush_core;
  logic             w_flush_any;
  logic [1:0]       w_req_state;
  logic             w_err_resolve;

  assign w_accept    = bus_valid & r_bus_ready;
  assign w_cmd_in    = bus_signals[c_BIT_RD:c_BIT_UPGR];
  assign w_cmd_legal = $onehot(w_cmd_in);

  for (genvar g = 0; g < 4; g++) begin : g_core
    mesi_next_state_calc u_calc (
      .i_cmd          (r_cmd),
      .i_is_requester (r_req == 2'(g)),
      .i_cur_state    (r_snoop[2*g +: 2]),
      .o_nxt_state    (w_nxt[2*g +: 2]),
      .o_flush        (w_flush_vec[g])
    );
    assign w_changed[g] = (w_nxt[2*g +: 2] != r_snoop[2*g +: 2]);
    assign w_is_m[g]    = (r_snoop[2*g +: 2] == c_MESI_M);
    assign w_is_se[g]   = (r_snoop[2*g +: 2] == c_MESI_S) || (r_snoop[2*g +: 2] == c_MESI_E);
  end

  // Descending scan so the lowest-index Modified owner wins
  always_comb begin
    w_flush_core = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_flush_vec[i]) w_flush_core = 2'(i);
    end
  end

  assign w_flush_any   = |w_flush_vec;
  assign w_req_state   = r_snoop[{r_req, 1'b0} +: 2];
  assign w_err_resolve = ($countones(w_is_m) > 1)
                       || ((|w_is_m) && (|w_is_se))
                       || ((r_cmd == c_CMD_UPGR) && (w_req_state != c_MESI_S));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus_ready     = r_bus_ready;
    flush_req     = 1'b0;
    flush_core    = 2'd0;
    state_wr_en   = 4'd0;
    state_wr_data = 8'd0;
    txn_done      = 1'b0;
    txn_error     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_cmd_legal ? ST_SNOOP : ST_UPDATE;
      end
      ST_SNOOP: begin
        w_state_nxt = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        w_state_nxt = w_flush_any ? ST_FLUSH : ST_UPDATE;
      end
      ST_FLUSH: begin
        flush_req  = 1'b1;
        flush_core = r_flush_core;
        if (flush_ack || (r_tmo == c_TMO_LAST)) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        txn_done  = 1'b1;
        txn_error = r_err;
        if (!r_noop) begin
          state_wr_en   = w_changed | (4'b0001 << r_req);
          state_wr_data = w_nxt;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_ready  <= 1'b0;
      r_cmd        <= 3'd0;
      r_req        <= 2'd0;
      r_noop       <= 1'b0;
      r_err        <= 1'b0;
      r_snoop      <= 8'd0;
      r_flush_core <= 2'd0;
      r_tmo        <= '0;
    end else begin
      // Registered so ready stays low for the first edge after reset release
      r_bus_ready <= (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req  <= bus_signals[c_CORE_LSB +: 2];
            r_cmd  <= w_cmd_legal ? w_cmd_in : 3'd0;
            r_noop <= !w_cmd_legal;
            r_err  <= (|w_cmd_in) && !w_cmd_legal;
          end
        end
        ST_SNOOP: begin
          r_snoop <= snoop_state;
        end
        ST_RESOLVE: begin
          r_err        <= r_err | w_err_resolve;
          r_flush_core <= w_flush_core;
          r_tmo        <= '0;
        end
        ST_FLUSH: begin
          if (!flush_ack) begin
            if (r_tmo == c_TMO_LAST) r_err <= 1'b1;
            else                     r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MESI_BUS_STATS_EN
  logic r_flush_need;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_need <= 1'b0;
      cnt_busrd    <= '0;
      cnt_busrdx   <= '0;
      cnt_busupgr  <= '0;
      cnt_flush    <= '0;
    end else begin
      if (r_state == ST_IDLE && w_accept) r_flush_need <= 1'b0;
      if (r_state == ST_RESOLVE)          r_flush_need <= w_flush_any;
      if (r_state == ST_UPDATE && !r_noop) begin
        if (r_cmd == c_CMD_RD   && cnt_busrd   != '1) cnt_busrd   <= cnt_busrd + 1'b1;
        if (r_cmd == c_CMD_RDX  && cnt_busrdx  != '1) cnt_busrdx  <= cnt_busrdx + 1'b1;
        if (r_cmd == c_CMD_UPGR && cnt_busupgr != '1) cnt_busupgr <= cnt_busupgr + 1'b1;
        if (r_flush_need        && cnt_flush   != '1) cnt_flush   <= cnt_flush + 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
